// File: rtl/pingpong_sram_ctrl_if.sv
// Stream-side bundle of pingpong_sram_ctrl: valid/ready input, flush, valid/ready output.
// The controller takes the slave modport; a producer/consumer takes master.

interface pingpong_sram_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pingpong_sram_ctrl.sv
// Ping-pong controller for two sram_w16 banks: fills one bank while draining the other, in order.
// Optional macro PINGPONG_PARTIAL_FLUSH_EN lets `flush` close a partially filled bank.

module pingpong_sram_ctrl #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  pingpong_sram_ctrl_if.slave bus,
  output logic                CEN_EVEN,
  output logic                WEN_EVEN,
  output logic [ADDR_W-1:0]   A_EVEN,
  input  logic [WIDTH-1:0]    Q_EVEN,
  output logic                CEN_ODD,
  output logic                WEN_ODD,
  output logic [ADDR_W-1:0]   A_ODD,
  input  logic [WIDTH-1:0]    Q_ODD,
  output logic [WIDTH-1:0]    D,
  output logic [1:0]          bank_full
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int FIFO_D = 4;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_state_e;

  function automatic logic holds_data(input bank_state_e s);
    return (s == B_FULL) || (s == B_DRAINING);
  endfunction

  // Bank bookkeeping: index 0 is EVEN, index 1 is ODD.
  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic [LEN_W-1:0]  len_q   [2];
  logic [LEN_W-1:0]  len_d   [2];
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;

  // Registered SRAM pins.
  logic [1:0]        cen_q, cen_d;
  logic [1:0]        wen_q, wen_d;
  logic [ADDR_W-1:0] a_q [2];
  logic [ADDR_W-1:0] a_d [2];
  logic [WIDTH-1:0]  d_q, d_d;

  // Read return pipeline: stage 1 = command on pins, stage 2 = SRAM sampled, Q valid.
  logic v1_q, v2_q, b1_q, b2_q;

  logic [WIDTH-1:0]  fifo_q [FIFO_D];
  logic [1:0]        fifo_wp_q, fifo_rp_q;
  logic [2:0]        fifo_cnt_q;

  logic              accept, rd_issue, flush_close, pop;
  logic [2:0]        inflight;
  logic [WIDTH-1:0]  q_sel;

  assign bus.in_ready = (state_q[wbank_q] == B_EMPTY) || (state_q[wbank_q] == B_FILLING);
  assign accept       = bus.in_valid && bus.in_ready;
  assign inflight     = 3'(v1_q) + 3'(v2_q);
  // Issue only when the FIFO is guaranteed room for every read already in flight.
  assign rd_issue     = holds_data(state_q[rbank_q]) && ((fifo_cnt_q + inflight) < 3'(FIFO_D));

`ifdef PINGPONG_PARTIAL_FLUSH_EN
  assign flush_close = bus.flush && (state_q[wbank_q] == B_FILLING);
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_close  = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cen_d   = 2'b11;
    wen_d   = 2'b11;
    a_d     = a_q;
    d_d     = d_q;

    if (accept) begin
      cen_d[wbank_q]   = 1'b0;
      wen_d[wbank_q]   = 1'b0;
      a_d[wbank_q]     = wptr_q;
      d_d              = bus.in_data;
      wptr_d           = wptr_q + ADDR_W'(1);
      state_d[wbank_q] = B_FILLING;
    end

    if (accept && (wptr_q == ADDR_W'(DEPTH - 1))) begin
      state_d[wbank_q] = B_FULL;
      len_d[wbank_q]   = LEN_W'(DEPTH);
      wptr_d           = '0;
      wbank_d          = ~wbank_q;
    end else if (flush_close) begin
      state_d[wbank_q] = B_FULL;
      len_d[wbank_q]   = {1'b0, wptr_q} + LEN_W'(accept);
      wptr_d           = '0;
      wbank_d          = ~wbank_q;
    end

    // The read bank always differs from a bank that can accept, so both sides may fire together.
    if (rd_issue) begin
      cen_d[rbank_q]   = 1'b0;
      a_d[rbank_q]     = rptr_q;
      state_d[rbank_q] = B_DRAINING;
      rptr_d           = rptr_q + ADDR_W'(1);
      if (({1'b0, rptr_q} + LEN_W'(1)) == len_q[rbank_q]) begin
        state_d[rbank_q] = B_EMPTY;
        rptr_d           = '0;
        rbank_d          = ~rbank_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= B_EMPTY;
        len_q[b]   <= '0;
        a_q[b]     <= '0;
      end
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cen_q   <= 2'b11;
      wen_q   <= 2'b11;
      d_q     <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      b1_q    <= 1'b0;
      b2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      a_q     <= a_d;
      d_q     <= d_d;
      v1_q    <= rd_issue;
      b1_q    <= rbank_q;
      v2_q    <= v1_q;
      b2_q    <= b1_q;
    end
  end

  assign q_sel = b2_q ? Q_ODD : Q_EVEN;
  assign pop   = bus.out_valid && bus.out_ready;

  // NOTE: the FIFO storage is reset because out_data shows the head entry and must read 0 after reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_D; i++) fifo_q[i] <= '0;
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (v2_q) begin
        fifo_q[fifo_wp_q] <= q_sel;
        fifo_wp_q         <= fifo_wp_q + 2'd1;
      end
      if (pop) fifo_rp_q <= fifo_rp_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + 3'(v2_q) - 3'(pop);
    end
  end

  assign bus.out_valid = (fifo_cnt_q != 3'd0);
  assign bus.out_data  = fifo_q[fifo_rp_q];

  assign CEN_EVEN  = cen_q[0];
  assign WEN_EVEN  = wen_q[0];
  assign A_EVEN    = a_q[0];
  assign CEN_ODD   = cen_q[1];
  assign WEN_ODD   = wen_q[1];
  assign A_ODD     = a_q[1];
  assign D         = d_q;
  assign bank_full = {holds_data(state_q[1]), holds_data(state_q[0])};

endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Scoreboard bench for pingpong_sram_ctrl with behavioural SRAM banks; expected output is arrival order.
// Build with PINGPONG_PARTIAL_FLUSH_EN defined to exercise partial flush.

module tb_pingpong_sram_ctrl;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  pingpong_sram_ctrl_if #(.WIDTH(WIDTH)) bus ();

  logic              CEN_EVEN, WEN_EVEN, CEN_ODD, WEN_ODD;
  logic [ADDR_W-1:0] A_EVEN, A_ODD;
  logic [WIDTH-1:0]  Q_EVEN, Q_ODD, D;
  logic [1:0]        bank_full;

  pingpong_sram_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .CEN_EVEN  (CEN_EVEN),
    .WEN_EVEN  (WEN_EVEN),
    .A_EVEN    (A_EVEN),
    .Q_EVEN    (Q_EVEN),
    .CEN_ODD   (CEN_ODD),
    .WEN_ODD   (WEN_ODD),
    .A_ODD     (A_ODD),
    .Q_ODD     (Q_ODD),
    .D         (D),
    .bank_full (bank_full)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Behavioural sram_w16 pair: one-edge read latency.
  logic [WIDTH-1:0] mem_even [DEPTH];
  logic [WIDTH-1:0] mem_odd  [DEPTH];
  always @(posedge CLK) begin
    if (!CEN_EVEN) begin
      if (!WEN_EVEN) mem_even[A_EVEN] <= D;
      else           Q_EVEN <= mem_even[A_EVEN];
    end
    if (!CEN_ODD) begin
      if (!WEN_ODD) mem_odd[A_ODD] <= D;
      else          Q_ODD <= mem_odd[A_ODD];
    end
  end

  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Monitor: records accepts into the scoreboard, compares every output transfer, and watches the pins.
  int first_valid_cyc = -1;
  int last_even_rd15  = -1;
  int rd_cnt          = 0;
  int last_wr_bank    = -1;
  bit saw_overlap     = 1'b0;
  int wr_log [$];

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got 0x%0h with nothing expected", bus.out_data);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!CEN_EVEN && !WEN_EVEN) begin wr_log.push_back(0); last_wr_bank = 0; end
      if (!CEN_ODD && !WEN_ODD)   begin wr_log.push_back(1); last_wr_bank = 1; end
      if (!CEN_EVEN && WEN_EVEN) begin
        rd_cnt++;
        if (A_EVEN == 4'd15) last_even_rd15 = cyc;
      end
      if (!CEN_ODD && WEN_ODD) rd_cnt++;
      if (!CEN_ODD && !WEN_ODD && !CEN_EVEN && WEN_EVEN) saw_overlap = 1'b1;
    end
  end

  // out_ready pattern: 0 hold low, 1 hold high, 2 toggle, 3 random.
  int or_mode = 0;
  always @(posedge CLK) begin
    #1;
    case (or_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      2:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [31:0] w, output int acc_edge);
    int  k    = 0;
    bit  took = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!took && k < 300) begin
      @(negedge CLK);
      took = bus.in_ready;
      @(posedge CLK);
      #1;
      k++;
    end
    if (!took) fail_timeout("send");
    acc_edge     = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget, input int leftover);
    int k = 0;
    while (exp_q.size() != leftover && k < budget) begin
      @(posedge CLK);
      k++;
    end
    #1;
    check(name, exp_q.size(), leftover);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge CLK);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {bus.in_ready, bus.out_valid, bank_full}, 4'b1000);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_pins"}, {CEN_EVEN, WEN_EVEN, CEN_ODD, WEN_ODD, A_EVEN, A_ODD}, 12'hF00);
    check({tag, "_d"}, D, 0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e0, e15, base, bad, k;
    bit took;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("t0_reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // 32-word stream at full rate.
    or_mode = 1;
    @(posedge CLK);
    #1;
    wr_log.delete();
    first_valid_cyc = -1;
    base = n_out;
    for (int i = 0; i < 32; i++) begin
      send(32'(i), e);
      if (i == 0)  e0  = e;
      if (i == 15) e15 = e;
    end
    check("t1_in_rate", e - e0, 31);
    wait_drain("t1_drain", 200, 0);
    check("t1_out_count", n_out - base, 32);
    check("t1_fill_to_out", first_valid_cyc, e15 + 3);
    check("t1_wr_count", wr_log.size(), 32);
    bad = 0;
    foreach (wr_log[i]) if (wr_log[i] != ((i / DEPTH) % 2)) bad++;
    check("t1_wr_bank_order", bad, 0);

    // Backpressure: both banks full, then release.
    or_mode = 0;
    do_reset();
    rd_cnt = 0;
    base   = n_out;
    for (int i = 0; i < 32; i++) send(32'h100 + 32'(i), e);
    @(negedge CLK);
    check("t2_in_ready_low", bus.in_ready, 0);
    check("t2_bank_full", bank_full, 2'b11);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h200;
    repeat (10) @(negedge CLK);
    check("t2_reads_stalled", rd_cnt, 4);
    check("t2_still_blocked", bus.in_ready, 0);
    check("t2_no_output", n_out - base, 0);
    last_even_rd15 = -1;
    or_mode = 1;
    k    = 0;
    took = 1'b0;
    while (!took && k < 100) begin
      @(negedge CLK);
      took = bus.in_ready;
      @(posedge CLK);
      #1;
      k++;
    end
    bus.in_valid = 1'b0;
    if (!took) fail_timeout("t2_refill");
    else       check("t2_refill_edge", cyc, last_even_rd15 + 1);
    wait_drain("t2_drain", 200, 1);
    check("t2_out_count", n_out - base, 32);

    // 64 words with out_ready toggling.
    or_mode = 2;
    do_reset();
    saw_overlap = 1'b0;
    base = n_out;
    for (int i = 0; i < 64; i++) send($urandom, e);
    wait_drain("t3_drain", 2000, 0);
    check("t3_out_count", n_out - base, 64);
    check("t3_overlap_seen", saw_overlap, 1);

    // Reset mid-fill and mid-drain.
    or_mode = 1;
    do_reset();
    for (int i = 0; i < 7; i++) send(32'hA0 + 32'(i), e);
    RESET_N = 1'b0;
    exp_q.delete();
    #2;
    check_reset_vals("t4_midfill");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    base = n_out;
    for (int i = 0; i < 16; i++) send(32'h300 + 32'(i), e);
    k = 0;
    while ((n_out - base) < 5 && k < 100) begin
      @(posedge CLK);
      k++;
    end
    #1;
    if ((n_out - base) < 5) fail_timeout("t4_middrain");
    RESET_N = 1'b0;
    exp_q.delete();
    #2;
    check_reset_vals("t4_middrain");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    base = n_out;
    for (int i = 0; i < 16; i++) send(32'h500 + 32'(i), e);
    wait_drain("t4_drain", 200, 0);
    check("t4_out_count", n_out - base, 16);

    // Flush after 5 words.
    do_reset();
    base = n_out;
    for (int i = 0; i < 5; i++) send(32'h600 + 32'(i), e);
    pulse_flush();
    repeat (20) @(posedge CLK);
    #1;
`ifdef PINGPONG_PARTIAL_FLUSH_EN
    check("t5_partial_out", n_out - base, 5);
    send(32'h700, e);
    @(negedge CLK);
    #1;
    check("t5_next_bank_odd", last_wr_bank, 1);
    pulse_flush();
    wait_drain("t5_drain", 200, 0);
    check("t5_out_count", n_out - base, 6);
`else
    check("t5_flush_ignored", n_out - base, 0);
    for (int i = 5; i < 16; i++) send(32'h600 + 32'(i), e);
    wait_drain("t5_drain", 200, 0);
    check("t5_out_count", n_out - base, 16);
`endif

    // Random traffic, random out_ready, random flush pulses.
    or_mode = 3;
    do_reset();
    base = n_out;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
      bus.flush = ($urandom_range(0, 15) == 0);
      send($urandom, e);
      bus.flush = 1'b0;
    end
    pulse_flush();
    wait_drain("t6_drain", 3000, 0);
    check("t6_out_count", n_out - base, 160);

    repeat (5) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
